// File: rtl/tt_eval_pkg.sv
// Shared types and index helpers for the truth-table evaluator.
// Row r of a table lives at bit ROWS-1-r (row 0 is the MSB of the hex name).
package tt_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int rows_f(input int n);
    return 1 << n;
  endfunction

  function automatic int row_bit_f(input int rows, input int r);
    return rows - 1 - r;
  endfunction

endpackage

// File: rtl/tt_lut_sel.sv
// One channel's combinational lookup: selects the table bit for a row index.
module tt_lut_sel
  import tt_eval_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int ROWS = rows_f(N_IN)
) (
  input  logic [ROWS-1:0] tt_i,
  input  logic [N_IN-1:0] row_i,
  output logic            bit_o
);

  logic [N_IN-1:0] idx;

  assign idx   = N_IN'(row_bit_f(ROWS, int'(row_i)));
  assign bit_o = tt_i[idx];

endmodule

// File: rtl/tt_eval_engine.sv
// Registered N_CH-channel truth-table evaluator with valid/ready streaming
// and a sweep mode that reassembles every stored table row by row.
module tt_eval_engine
  import tt_eval_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_CH = 4,
  localparam int ROWS = rows_f(N_IN),
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ROWS-1:0]      cfg_tt,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH-1:0]      out_bits,
  input  logic                 sweep_start,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic [N_CH*ROWS-1:0] sweep_tt
);

  localparam int CNT_W = $clog2(ROWS) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic [N_CH-1:0]  out_bits_q;
  logic [N_CH-1:0]  lut_bits;
  logic [N_IN-1:0]  row_sel;
  logic [ROWS-1:0]  row_hit;
  logic             accept;
  logic             sweep_clr;

  assign sweep_busy = (state_q == SWEEP);
  assign sweep_done = (state_q == DONE);
  assign in_ready   = !sweep_busy && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign sweep_clr  = (state_q == IDLE) && sweep_start;
  assign out_valid  = out_valid_q;
  assign out_bits   = out_bits_q;

  // The sweep borrows the stream lookup instances by steering their row input.
  assign row_sel = sweep_busy ? cnt_q[N_IN-1:0] : in_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROWS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_bits_q  <= lut_bits;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-hot bit position written this sweep cycle; all zero outside SWEEP.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_hit
    assign row_hit[gi] = sweep_busy && (cnt_q == CNT_W'(row_bit_f(ROWS, gi)));
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [ROWS-1:0] tt_q;
    logic [ROWS-1:0] sw_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        tt_q <= '0;
      end else if (cfg_we && !sweep_busy && (cfg_ch == CH_W'(gi))) begin
        tt_q <= cfg_tt;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || sweep_clr) begin
        sw_q <= '0;
      end else begin
        sw_q <= (sw_q & ~row_hit) | (row_hit & {ROWS{lut_bits[gi]}});
      end
    end

    tt_lut_sel #(
      .N_IN (N_IN),
      .ROWS (ROWS)
    ) u_sel (
      .tt_i  (tt_q),
      .row_i (row_sel),
      .bit_o (lut_bits[gi])
    );

    assign sweep_tt[gi*ROWS +: ROWS] = sw_q;
  end

endmodule

// File: tb/tb_tt_eval_engine.sv
// Randomised self-checking bench for tt_eval_engine (N_IN=3, N_CH=4).
module tb_tt_eval_engine;

  localparam int N_IN = 3;
  localparam int N_CH = 4;
  localparam int ROWS = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_we;
  logic [1:0]           cfg_ch;
  logic [ROWS-1:0]      cfg_tt;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN-1:0]      in_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_CH-1:0]      out_bits;
  logic                 sweep_start;
  logic                 sweep_busy;
  logic                 sweep_done;
  logic [N_CH*ROWS-1:0] sweep_tt;

  always #5 clk = ~clk;

  tt_eval_engine #(.N_IN(N_IN), .N_CH(N_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_tt      (cfg_tt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_tt    (sweep_tt)
  );

  // Reference model: the stored tables as plain bytes.
  logic [ROWS-1:0] m_tt [N_CH];
  int n_checks = 0;
  int n_fail   = 0;

  // Function value for row r is table bit ROWS-1-r, i.e. the table shifted right.
  function automatic logic [N_CH-1:0] exp_bits(input int row);
    logic [N_CH-1:0] b;
    logic [ROWS-1:0] t;
    for (int c = 0; c < N_CH; c++) begin
      t    = m_tt[c] >> (ROWS - 1 - row);
      b[c] = t[0];
    end
    return b;
  endfunction

  function automatic logic [N_CH*ROWS-1:0] exp_sweep();
    logic [N_CH*ROWS-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c*ROWS +: ROWS] = m_tt[c];
    return r;
  endfunction

  task automatic write_cfg(input int ch, input logic [ROWS-1:0] tt);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_ch = ch[1:0];
    cfg_tt = tt;
    @(negedge clk);
    cfg_we = 1'b0;
    if (ch < N_CH) m_tt[ch] = tt;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < N_CH; c++) m_tt[c] = '0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_bits !== '0) begin n_fail++; $display("FAIL reset_out_bits: got %h expected 0", out_bits); end
    n_checks++; if (sweep_busy !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_busy: got %b expected 0", sweep_busy); end
    n_checks++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_done: got %b expected 0", sweep_done); end
    n_checks++; if (sweep_tt !== '0) begin n_fail++; $display("FAIL reset_sweep_tt: got %h expected 0", sweep_tt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_stream();
    logic [N_CH-1:0] eb;
    write_cfg(0, 8'h9C);
    for (int c = 1; c < N_CH; c++) write_cfg(c, 8'($urandom));
    out_ready = 1'b1;
    for (int r = 0; r <= ROWS; r++) begin
      @(negedge clk);
      if (r > 0) begin
        eb = exp_bits(r - 1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid row %0d: got %b expected 1", r - 1, out_valid); end
        n_checks++; if (out_bits !== eb) begin n_fail++; $display("FAIL stream_bits row %0d: got %b expected %b", r - 1, out_bits, eb); end
        $display("stream: row=%0d bits=%b", r - 1, out_bits);
      end
      if (r < ROWS) begin
        in_valid = 1'b1;
        in_vec   = r[N_IN-1:0];
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready row %0d: got %b expected 1", r, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random_stream();
    logic            mv = 1'b0;
    logic [N_CH-1:0] mb = '0;
    logic            er;
    for (int c = 0; c < N_CH; c++) write_cfg(c, 8'($urandom));
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== mv) begin n_fail++; $display("FAIL rand_valid %0d: got %b expected %b", i, out_valid, mv); end
      if (mv) begin
        n_checks++; if (out_bits !== mb) begin n_fail++; $display("FAIL rand_bits %0d: got %b expected %b", i, out_bits, mb); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_vec    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = !mv || out_ready;
      n_checks++; if (in_ready !== er) begin n_fail++; $display("FAIL rand_ready %0d: got %b expected %b", i, in_ready, er); end
      if (in_valid && er) begin
        mv = 1'b1;
        mb = exp_bits(int'(in_vec));
        $display("rand: beat %0d vec=%0d expect=%b", i, in_vec, mb);
      end else if (out_ready) begin
        mv = 1'b0;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [N_IN-1:0] v1, v2;
    logic [N_CH-1:0] b1, b2;
    v1 = 3'($urandom_range(0, 7));
    v2 = ~v1;
    b1 = exp_bits(int'(v1));
    b2 = exp_bits(int'(v2));
    @(negedge clk);
    in_valid  = 1'b1;
    in_vec    = v1;
    out_ready = 1'b0;
    @(negedge clk);
    in_vec = v2;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low %0d: got %b expected 0", i, in_ready); end
      n_checks++; if (out_bits !== b1) begin n_fail++; $display("FAIL bp_stable %0d: got %b expected %b", i, out_bits, b1); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    n_checks++; if (out_bits !== b2) begin n_fail++; $display("FAIL bp_next_bits: got %b expected %b", out_bits, b2); end
    $display("backpressure: held=%b next=%b", b1, out_bits);
    in_valid = 1'b0;
  endtask

  task automatic test_cfg_collision();
    logic [N_CH-1:0] eb;
    write_cfg(0, 8'h9C);
    eb = exp_bits(5);
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = 3'd5;
    cfg_we   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_tt   = 8'h00;
    @(negedge clk);
    n_checks++; if (out_bits[0] !== eb[0]) begin n_fail++; $display("FAIL collide_old_table: got %b expected %b", out_bits[0], eb[0]); end
    cfg_we  = 1'b0;
    m_tt[0] = 8'h00;
    eb      = exp_bits(5);
    @(negedge clk);
    n_checks++; if (out_bits[0] !== eb[0]) begin n_fail++; $display("FAIL collide_new_table: got %b expected %b", out_bits[0], eb[0]); end
    $display("collision: new-table row5=%b", out_bits[0]);
    in_valid = 1'b0;
  endtask

  task automatic test_sweep(input bit rand_tt, input bit poke);
    logic [N_IN-1:0] ev;
    logic [N_CH-1:0] eb;
    if (rand_tt) begin
      for (int c = 0; c < N_CH; c++) write_cfg(c, 8'($urandom));
    end else begin
      write_cfg(0, 8'h9C);
      write_cfg(1, 8'h96);
      write_cfg(2, 8'hE8);
      write_cfg(3, 8'h01);
    end
    ev = 3'($urandom_range(0, 7));
    eb = exp_bits(int'(ev));
    @(negedge clk);
    out_ready   = 1'b1;
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_vec      = ev;
    for (int k = 1; k <= ROWS + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sweep_start = 1'b0;
        n_checks++; if (out_bits !== eb || out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_start_beat: got %b/%b expected 1/%b", out_valid, out_bits, eb); end
      end
      if (poke && k == 3) begin
        cfg_we      = 1'b1;
        cfg_ch      = 2'd1;
        cfg_tt      = ~m_tt[1];
        sweep_start = 1'b1;
      end
      if (poke && k == 4) begin
        cfg_we      = 1'b0;
        sweep_start = 1'b0;
      end
      if (k == ROWS) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_no_accept: got %b expected 0", out_valid); end
        in_valid = 1'b0;
      end
      n_checks++; if (sweep_busy !== (k <= ROWS)) begin n_fail++; $display("FAIL sweep_busy k=%0d: got %b expected %b", k, sweep_busy, k <= ROWS); end
      n_checks++; if (sweep_done !== (k == ROWS + 1)) begin n_fail++; $display("FAIL sweep_done k=%0d: got %b expected %b", k, sweep_done, k == ROWS + 1); end
      #1;
      n_checks++; if (in_ready !== (k > ROWS)) begin n_fail++; $display("FAIL sweep_ready k=%0d: got %b expected %b", k, in_ready, k > ROWS); end
      if (k > ROWS) begin
        n_checks++; if (sweep_tt !== exp_sweep()) begin n_fail++; $display("FAIL sweep_tt k=%0d: got %h expected %h", k, sweep_tt, exp_sweep()); end
      end
    end
    $display("sweep: rand=%0d poke=%0d tt=%h", rand_tt, poke, sweep_tt);
    if (poke) begin
      eb = exp_bits(0);
      in_valid = 1'b1;
      in_vec   = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (out_bits !== eb) begin n_fail++; $display("FAIL sweep_cfg_ignored: got %b expected %b", out_bits, eb); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [N_IN-1:0] v;
    @(negedge clk);
    sweep_start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sweep_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) m_tt[c] = '0;
    n_checks++; if (sweep_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", sweep_busy); end
    n_checks++; if (sweep_tt !== exp_sweep()) begin n_fail++; $display("FAIL midrst_sweep_tt: got %h expected %h", sweep_tt, exp_sweep()); end
    rst = 1'b0;
    for (int k = 0; k < ROWS + 2; k++) begin
      n_checks++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done %0d: got %b expected 0", k, sweep_done); end
      @(negedge clk);
    end
    v        = 3'($urandom_range(0, 7));
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_bits !== exp_bits(int'(v))) begin n_fail++; $display("FAIL midrst_tables: got %b expected %b", out_bits, exp_bits(int'(v))); end
    $display("reset mid-sweep: row=%0d bits=%b", v, out_bits);
  endtask

  initial begin
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_tt      = '0;
    in_valid    = 1'b0;
    in_vec      = '0;
    out_ready   = 1'b1;
    sweep_start = 1'b0;
    test_reset();
    test_stream();
    test_random_stream();
    test_backpressure();
    test_cfg_collision();
    test_sweep(1'b0, 1'b0);
    test_sweep(1'b0, 1'b1);
    test_sweep(1'b1, 1'b0);
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_eval_engine.md
# tt_eval_engine

Parametrised, registered truth-table evaluator for the 3-input circuit-scoring flow, generalised to N_IN inputs and N_CH parallel logic functions. Each channel holds a programmable 2^N_IN-bit truth table (same hex encoding used to name designs, e.g. 0x9C). Input vectors stream through a valid/ready pipeline. A sweep mode enumerates every input row and reassembles the tables, so a bench can self-check any stored function against its hex name.

## Interface
- N_IN, 3, number of function inputs (1..6)
- N_CH, 4, number of independent functions evaluated in parallel (1..16)
- ROWS, 2**N_IN, derived; truth-table width per channel
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write cfg_tt into channel cfg_ch
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel
- cfg_tt  in  ROWS  truth table, MSB-first encoding (see Operation)
- in_valid  in  1  input vector offered
- in_ready  out  1  engine can accept a vector
- in_vec  in  N_IN  input vector; in_vec[N_IN-1] is the most significant row-index bit
- out_valid  out  1  out_bits holds a result
- out_ready  in  1  consumer accepts result
- out_bits  out  N_CH  bit c = function c evaluated on the accepted vector
- sweep_start  in  1  request a full-table sweep
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse, sweep_tt valid
- sweep_tt  out  N_CH*ROWS  recovered tables; channel c at [c*ROWS +: ROWS]

## Operation
- Encoding: row r = in_vec as unsigned integer. Function value = tt[ROWS-1-r]. Row 0 is the table MSB. With this encoding, 0x9C for N_IN=3 gives outputs 1,0,0,1,1,1,0,0 for rows 0..7.
- Config: cfg_we writes the table register on the next edge. An evaluation accepted in the same cycle uses the old table. cfg_we is ignored while sweep_busy. cfg_ch >= N_CH is ignored.
- Stream: in_ready = !sweep_busy && (!out_valid || out_ready). A beat is accepted when in_valid && in_ready. out_bits/out_valid register on the next edge. out_bits stays stable while out_valid && !out_ready.
- FSM states:
  - IDLE: sweep_start in IDLE moves to SWEEP, clears the row counter, and clears sweep_tt. sweep_start in any other state is ignored.
  - SWEEP: each cycle, evaluate row = counter for all channels and write the result into sweep_tt at bit ROWS-1-row of each channel. Increment the counter. After row ROWS-1, go to DONE. in_ready is 0; a pending out beat still drains.
  - DONE: one cycle, sweep_done = 1, then IDLE.
- sweep_tt holds its value until the next accepted sweep_start or reset.
- Counter is $clog2(ROWS)+1 bits wide, so the terminal compare has no wrap ambiguity.
- Simultaneous sweep_start and accepted in beat in IDLE: the beat is accepted and evaluated normally, and the sweep starts the same edge. From the next cycle in_ready = 0.

## Timing
- Stream latency: 1 cycle from accept to out_valid. Throughput is one vector per cycle when out_ready = 1.
- Sweep: start accepted at edge t. sweep_busy = 1 for cycles t+1..t+ROWS. sweep_done = 1 in cycle t+ROWS+1, with sweep_tt final in that cycle. Total ROWS+1 cycles.
- Reset values: all tables 0, out_valid 0, out_bits 0, sweep_busy 0, sweep_done 0, sweep_tt 0, FSM IDLE, counter 0. in_ready = 1 after reset.
- Reset mid-sweep: returns to IDLE on the same edge. No sweep_done; sweep_tt reads 0.

## Structure
- Package tt_eval_pkg: state enum (IDLE, SWEEP, DONE), function rows_f(n) = 1<<n, row-to-bit index function (ROWS-1-r).
- Sub-module tt_lut_sel: one channel's combinational row select (tt, row -> bit). Instantiated N_CH times for the stream path. The sweep path shares the same instances through a row mux (counter during SWEEP, in_vec otherwise).

## Test plan
- Write channel 0 = 0x9C, N_IN=3. Stream rows 0..7 with out_ready=1 -> out_bits[0] = 1,0,0,1,1,1,0,0, one per cycle, each 1 cycle after accept.
- Write channels 0..3 = 0x9C, 0x96, 0xE8, 0x01, then sweep -> sweep_done 9 cycles after start; sweep_tt = {0x01,0xE8,0x96,0x9C}; in_ready low for cycles 1..8.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, out_bits stable. Release -> next beat accepted the same cycle.
- Accept row 5 on channel 0 in the same cycle as a cfg_we changing 0x9C to 0x00 -> out_bits[0]=1 (old table). Next row 5 -> 0.
- Assert rst at sweep cycle 4 -> sweep_busy=0 next cycle, no sweep_done, sweep_tt=0, tables=0.
- cfg_we during sweep, and sweep_start during sweep -> both ignored; table and sweep result unchanged.
